// File: rtl/uart_regs_pkg.sv
// Shared UART register-port definitions: register addresses, LSR masks,
// arbiter FSM states and the request payload selected by the arbiter.
package uart_regs_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(16);

    localparam logic [ADDR_W-1:0] RBR_THR = 3'd0;
    localparam logic [ADDR_W-1:0] LCR     = 3'd3;
    localparam logic [ADDR_W-1:0] LSR     = 3'd5;

    localparam logic [DATA_W-1:0] LSR_DR   = 8'h01;
    localparam logic [DATA_W-1:0] LSR_TEMT = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } reg_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~last;
        end
    end

endmodule

// File: rtl/uart_reg_arbiter.sv
// Shares the UART register port between two requesters, running the
// address-setup / one-cycle-strobe / read-wait sequence of the register file.
module uart_reg_arbiter
    import uart_regs_pkg::*;
#(
    parameter int unsigned RD_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              i_tx_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              i_rx_en,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata
);

    state_e             state, state_d;
    logic               last, last_d;
    logic               cur_we, cur_we_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               pick;
    reg_req_t           sel;

    logic               tx_en_d, rx_en_d, ack0_d, ack1_d;
    logic [ADDR_W-1:0]  waddr_d, raddr_d;
    logic [DATA_W-1:0]  wdata_d, rdata0_d, rdata1_d;

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last),
        .grant (pick)
    );

    assign sel = pick ? {we1, addr1, wdata1} : {we0, addr0, wdata0};

    // Next-state and next-output logic; `last` doubles as the granted port.
    always_comb begin
        state_d  = state;
        last_d   = last;
        cur_we_d = cur_we;
        cnt_d    = cnt;
        tx_en_d  = 1'b0;
        rx_en_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        waddr_d  = waddr;
        wdata_d  = wdata;
        raddr_d  = raddr;
        rdata0_d = rdata0;
        rdata1_d = rdata1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    last_d   = pick;
                    cur_we_d = sel.we;
                    if (sel.we) begin
                        waddr_d = sel.addr;
                        wdata_d = sel.wdata;
                    end else begin
                        raddr_d = sel.addr;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                tx_en_d = cur_we;
                rx_en_d = ~cur_we;
                state_d = STROBE;
            end
            STROBE: begin
                if (cur_we) begin
                    ack0_d  = ~last;
                    ack1_d  = last;
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_WAIT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    if (last) begin
                        rdata1_d = rdata;
                    end else begin
                        rdata0_d = rdata;
                    end
                    ack0_d  = ~last;
                    ack1_d  = last;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; pointer reset so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cur_we  <= 1'b0;
            cnt     <= '0;
            i_tx_en <= 1'b0;
            i_rx_en <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            raddr   <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state   <= state_d;
            last    <= last_d;
            cur_we  <= cur_we_d;
            cnt     <= cnt_d;
            i_tx_en <= tx_en_d;
            i_rx_en <= rx_en_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            waddr   <= waddr_d;
            wdata   <= wdata_d;
            raddr   <= raddr_d;
            rdata0  <= rdata0_d;
            rdata1  <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Bench for uart_reg_arbiter: directed timing scenarios plus a randomized
// run checked against a transaction-level arbitration/latency model.
module tb_uart_reg_arbiter;
    import uart_regs_pkg::*;

    localparam int RDW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [2:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0, rdata = 0;
    logic       ack0, ack1, i_tx_en, i_rx_en;
    logic [7:0] rdata0, rdata1, wdata;
    logic [2:0] waddr, raddr;

    logic       req_b = 0, we_b = 0;
    logic [2:0] addr_b = 0;
    logic [7:0] wdata_b = 0, rdata_b = 0;
    logic       ack_b, ack1_b, tx_b, rx_b;
    logic [7:0] rdata0_b, rdata1_b, wdata_bo;
    logic [2:0] waddr_b, raddr_b;

    uart_reg_arbiter #(.RD_WAIT(RDW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .i_tx_en(i_tx_en), .waddr(waddr), .wdata(wdata),
        .i_rx_en(i_rx_en), .raddr(raddr), .rdata(rdata)
    );

    uart_reg_arbiter #(.RD_WAIT(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req_b), .we0(we_b), .addr0(addr_b), .wdata0(wdata_b), .ack0(ack_b), .rdata0(rdata0_b),
        .req1(1'b0), .we1(1'b0), .addr1(3'd0), .wdata1(8'h00), .ack1(ack1_b), .rdata1(rdata1_b),
        .i_tx_en(tx_b), .waddr(waddr_b), .wdata(wdata_bo),
        .i_rx_en(rx_b), .raddr(raddr_b), .rdata(rdata_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       tr_tx[64], tr_rx[64], tr_a0[64], tr_a1[64];
    logic [2:0] tr_wa[64], tr_ra[64];
    logic [7:0] tr_wd[64], tr_r0[64], tr_r1[64];
    logic [7:0] rd_sched[64];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 0; req1 = 0; req_b = 0;
        step(2);
        rst = 1'b0;
    endtask

    // Records n cycles of one DUT's outputs; cycle 0 is the current cycle.
    task automatic capture(input int n, input bit use_b, input bit hold);
        for (int c = 0; c < n; c++) begin
            if (use_b) begin
                rdata_b = rd_sched[c];
                tr_tx[c] = tx_b;  tr_rx[c] = rx_b;  tr_a0[c] = ack_b;  tr_a1[c] = ack1_b;
                tr_wa[c] = waddr_b; tr_wd[c] = wdata_bo; tr_ra[c] = raddr_b;
                tr_r0[c] = rdata0_b; tr_r1[c] = rdata1_b;
                if (!hold && ack_b) req_b = 1'b0;
            end else begin
                rdata = rd_sched[c];
                tr_tx[c] = i_tx_en; tr_rx[c] = i_rx_en; tr_a0[c] = ack0; tr_a1[c] = ack1;
                tr_wa[c] = waddr; tr_wd[c] = wdata; tr_ra[c] = raddr;
                tr_r0[c] = rdata0; tr_r1[c] = rdata1;
                if (!hold && ack0) req0 = 1'b0;
                if (!hold && ack1) req1 = 1'b0;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_tests++; if ({i_tx_en, i_rx_en, ack0, ack1} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl got=%b exp=0000", {i_tx_en, i_rx_en, ack0, ack1}); end
        n_tests++; if ({waddr, wdata, raddr} !== 14'b0) begin n_fail++; $display("FAIL reset_bus got=%h exp=0", {waddr, wdata, raddr}); end
        n_tests++; if ({rdata0, rdata1} !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", {rdata0, rdata1}); end
        n_tests++; if ({tx_b, rx_b, ack_b, ack1_b, rdata0_b} !== 12'h0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", {tx_b, rx_b, ack_b, ack1_b, rdata0_b}); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        for (int c = 0; c < 64; c++) rd_sched[c] = 8'h00;
        req0 = 1; we0 = 1; addr0 = LCR; wdata0 = 8'h03;
        capture(8, 0, 0);
        n_tests++; if (tr_wa[1] !== LCR) begin n_fail++; $display("FAIL wr_waddr got=%0d exp=3", tr_wa[1]); end
        n_tests++; if (tr_wd[1] !== 8'h03) begin n_fail++; $display("FAIL wr_wdata got=%h exp=03", tr_wd[1]); end
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (tr_tx[c] !== (c == 2)) begin n_fail++; $display("FAIL wr_tx_en c=%0d got=%b exp=%b", c, tr_tx[c], c == 2); end
            n_tests++; if (tr_a0[c] !== (c == 3)) begin n_fail++; $display("FAIL wr_ack0 c=%0d got=%b exp=%b", c, tr_a0[c], c == 3); end
            n_tests++; if (tr_rx[c] !== 1'b0 || tr_a1[c] !== 1'b0) begin n_fail++; $display("FAIL wr_rx_ack1 c=%0d got=%b%b exp=00", c, tr_rx[c], tr_a1[c]); end
        end
    endtask

    task automatic test_read();
        for (int c = 0; c < 64; c++) rd_sched[c] = (c < 3) ? 8'hA5 : (LSR_DR | LSR_TEMT | 8'h20);
        req1 = 1; we1 = 0; addr1 = LSR;
        capture(10, 0, 0);
        n_tests++; if (tr_ra[1] !== LSR) begin n_fail++; $display("FAIL rd_raddr got=%0d exp=5", tr_ra[1]); end
        for (int c = 0; c < 10; c++) begin
            n_tests++; if (tr_rx[c] !== (c == 2)) begin n_fail++; $display("FAIL rd_rx_en c=%0d got=%b exp=%b", c, tr_rx[c], c == 2); end
            n_tests++; if (tr_a1[c] !== (c == 7)) begin n_fail++; $display("FAIL rd_ack1 c=%0d got=%b exp=%b", c, tr_a1[c], c == 7); end
            n_tests++; if (tr_tx[c] !== 1'b0 || tr_a0[c] !== 1'b0) begin n_fail++; $display("FAIL rd_tx_ack0 c=%0d got=%b%b exp=00", c, tr_tx[c], tr_a0[c]); end
            n_tests++; if (tr_r0[c] !== 8'h00) begin n_fail++; $display("FAIL rd_rdata0_held c=%0d got=%h exp=00", c, tr_r0[c]); end
        end
        n_tests++; if (tr_r1[6] !== 8'h00) begin n_fail++; $display("FAIL rd_rdata1_early got=%h exp=00", tr_r1[6]); end
        n_tests++; if (tr_r1[7] !== 8'h61) begin n_fail++; $display("FAIL rd_rdata1 got=%h exp=61", tr_r1[7]); end
    endtask

    task automatic test_both();
        int got;
        bit seq[2];
        do_reset();
        req0 = 1; we0 = 1; addr0 = LCR;     wdata0 = 8'hAA;
        req1 = 1; we1 = 1; addr1 = RBR_THR; wdata1 = 8'h55;
        capture(10, 0, 0);
        n_tests++; if ({tr_wa[1], tr_wd[1]} !== {LCR, 8'hAA}) begin n_fail++; $display("FAIL both_first got=%0d/%h exp=3/aa", tr_wa[1], tr_wd[1]); end
        n_tests++; if ({tr_wa[5], tr_wd[5]} !== {RBR_THR, 8'h55}) begin n_fail++; $display("FAIL both_second got=%0d/%h exp=0/55", tr_wa[5], tr_wd[5]); end
        for (int c = 0; c < 10; c++) begin
            n_tests++; if (tr_tx[c] !== (c == 2 || c == 6)) begin n_fail++; $display("FAIL both_tx c=%0d got=%b exp=%b", c, tr_tx[c], c == 2 || c == 6); end
            n_tests++; if ({tr_a0[c], tr_a1[c]} !== {c == 3, c == 7}) begin n_fail++; $display("FAIL both_ack c=%0d got=%b%b exp=%b%b", c, tr_a0[c], tr_a1[c], c == 3, c == 7); end
        end
        for (int r = 0; r < 4; r++) begin
            req0 = 1; we0 = 1'($urandom); addr0 = 3'($urandom); wdata0 = 8'($urandom);
            req1 = 1; we1 = 1'($urandom); addr1 = 3'($urandom); wdata1 = 8'($urandom);
            got = 0;
            for (int c = 0; c < 40 && got < 2; c++) begin
                if (ack0) begin req0 = 0; seq[got[0]] = 1'b0; got++; end
                else if (ack1) begin req1 = 0; seq[got[0]] = 1'b1; got++; end
                step(1);
            end
            n_tests++; if (got !== 2) begin n_fail++; $display("FAIL alt_done r=%0d got=%0d exp=2 acks", r, got); end
            n_tests++; if (seq[0] !== 1'b0 || seq[1] !== 1'b1) begin n_fail++; $display("FAIL alt_order r=%0d got=%b,%b exp=0,1", r, seq[0], seq[1]); end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 64; c++) rd_sched[c] = LSR_DR;
        req0 = 1; we0 = 0; addr0 = LSR;
        capture(30, 0, 1);
        for (int c = 0; c < 30; c++) begin
            n_tests++; if (tr_rx[c] !== (c >= 2 && (c - 2) % 8 == 0)) begin n_fail++; $display("FAIL b2b_rx c=%0d got=%b exp=%b", c, tr_rx[c], c >= 2 && (c - 2) % 8 == 0); end
            n_tests++; if (tr_a0[c] !== (c >= 7 && (c - 7) % 8 == 0)) begin n_fail++; $display("FAIL b2b_ack0 c=%0d got=%b exp=%b", c, tr_a0[c], c >= 7 && (c - 7) % 8 == 0); end
            n_tests++; if (tr_tx[c] !== 1'b0) begin n_fail++; $display("FAIL b2b_tx c=%0d got=%b exp=0", c, tr_tx[c]); end
        end
        for (int c = 0; c < 20 && !ack0; c++) step(1);
        n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL b2b_last_ack got=%b exp=1", ack0); end
        req0 = 0;
        step(2);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 64; c++) rd_sched[c] = 8'h99;
        req0 = 1; we0 = 1; addr0 = 3'd6; wdata0 = 8'h7E;
        capture(5, 0, 0);
        req1 = 1; we1 = 0; addr1 = LSR;
        capture(9, 0, 0);
        n_tests++; if (tr_r1[8] !== 8'h99) begin n_fail++; $display("FAIL mid_pre_read got=%h exp=99", tr_r1[8]); end
        req1 = 1; we1 = 0; addr1 = LCR;
        step(4);
        rst = 1'b1; req1 = 0;
        step(1);
        n_tests++; if ({i_tx_en, i_rx_en, ack0, ack1} !== 4'b0) begin n_fail++; $display("FAIL mid_ctl got=%b exp=0000", {i_tx_en, i_rx_en, ack0, ack1}); end
        n_tests++; if ({waddr, wdata, raddr, rdata0, rdata1} !== 30'b0) begin n_fail++; $display("FAIL mid_bus got=%h exp=0", {waddr, wdata, raddr, rdata0, rdata1}); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_tests++; if ({ack0, ack1, i_rx_en} !== 3'b0) begin n_fail++; $display("FAIL mid_no_ack c=%0d got=%b exp=000", c, {ack0, ack1, i_rx_en}); end
            step(1);
        end
        req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'h3C;
        capture(6, 0, 0);
        n_tests++; if ({tr_wa[1], tr_wd[1]} !== {3'd1, 8'h3C}) begin n_fail++; $display("FAIL post_rst_bus got=%0d/%h exp=1/3c", tr_wa[1], tr_wd[1]); end
        for (int c = 0; c < 6; c++) begin
            n_tests++; if ({tr_tx[c], tr_a0[c]} !== {c == 2, c == 3}) begin n_fail++; $display("FAIL post_rst c=%0d got=%b%b exp=%b%b", c, tr_tx[c], tr_a0[c], c == 2, c == 3); end
        end
    endtask

    task automatic test_rd_wait1();
        for (int c = 0; c < 64; c++) rd_sched[c] = (c < 3) ? 8'h11 : ((c == 3) ? 8'h22 : 8'h33);
        req_b = 1; we_b = 0; addr_b = LSR;
        capture(8, 1, 0);
        n_tests++; if (tr_ra[1] !== LSR) begin n_fail++; $display("FAIL rw1_raddr got=%0d exp=5", tr_ra[1]); end
        n_tests++; if (tr_r0[3] !== 8'h00) begin n_fail++; $display("FAIL rw1_rdata_early got=%h exp=00", tr_r0[3]); end
        n_tests++; if (tr_r0[4] !== 8'h22) begin n_fail++; $display("FAIL rw1_rdata got=%h exp=22", tr_r0[4]); end
        n_tests++; if ({tr_wa[7], tr_wd[7], tr_r1[7]} !== 19'b0) begin n_fail++; $display("FAIL rw1_unused got=%h exp=0", {tr_wa[7], tr_wd[7], tr_r1[7]}); end
        for (int c = 0; c < 8; c++) begin
            n_tests++; if (tr_rx[c] !== (c == 2)) begin n_fail++; $display("FAIL rw1_rx c=%0d got=%b exp=%b", c, tr_rx[c], c == 2); end
            n_tests++; if (tr_a0[c] !== (c == 4)) begin n_fail++; $display("FAIL rw1_ack c=%0d got=%b exp=%b", c, tr_a0[c], c == 4); end
            n_tests++; if ({tr_tx[c], tr_a1[c]} !== 2'b0) begin n_fail++; $display("FAIL rw1_tx_ack1 c=%0d got=%b exp=00", c, {tr_tx[c], tr_a1[c]}); end
        end
    endtask

    // Transaction-level model: grant at cycle g, strobe at g+2, ack at g+3
    // (write) or g+3+RDW (read) with rdata taken from cycle g+2+RDW.
    task automatic test_random();
        logic [7:0] rd_hist[1024];
        logic [7:0] m_rd[2];
        bit   busy, m_port, m_we, m_last;
        logic [2:0] m_addr;
        logic [7:0] m_wdata;
        int   m_strobe, m_ack, free_at;
        int   gap[2], n_done[2];
        bit   e_tx, e_rx, e_a0, e_a1;
        do_reset();
        busy = 0; m_last = 1; free_at = 0; m_rd[0] = 0; m_rd[1] = 0;
        m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_strobe = -1; m_ack = -1;
        gap[0] = $urandom_range(0, 3); gap[1] = $urandom_range(0, 3);
        n_done[0] = 0; n_done[1] = 0;
        for (int t = 0; t < 800; t++) begin
            e_tx = busy && m_we && t == m_strobe;
            e_rx = busy && !m_we && t == m_strobe;
            e_a0 = busy && !m_port && t == m_ack;
            e_a1 = busy && m_port && t == m_ack;
            if (busy && t == m_ack && !m_we) m_rd[m_port] = rd_hist[t - 1];
            n_tests++; if ({i_tx_en, i_rx_en} !== {e_tx, e_rx}) begin n_fail++; $display("FAIL rnd_strobe t=%0d got=%b%b exp=%b%b", t, i_tx_en, i_rx_en, e_tx, e_rx); end
            n_tests++; if ({ack0, ack1} !== {e_a0, e_a1}) begin n_fail++; $display("FAIL rnd_ack t=%0d got=%b%b exp=%b%b", t, ack0, ack1, e_a0, e_a1); end
            n_tests++; if ({rdata0, rdata1} !== {m_rd[0], m_rd[1]}) begin n_fail++; $display("FAIL rnd_rdata t=%0d got=%h/%h exp=%h/%h", t, rdata0, rdata1, m_rd[0], m_rd[1]); end
            if (e_tx) begin
                n_tests++; if ({waddr, wdata} !== {m_addr, m_wdata}) begin n_fail++; $display("FAIL rnd_wbus t=%0d got=%0d/%h exp=%0d/%h", t, waddr, wdata, m_addr, m_wdata); end
            end
            if (e_rx) begin
                n_tests++; if (raddr !== m_addr) begin n_fail++; $display("FAIL rnd_raddr t=%0d got=%0d exp=%0d", t, raddr, m_addr); end
            end
            if (t < 700) begin
                if (!req0) begin
                    if (gap[0] == 0) begin req0 = 1; we0 = 1'($urandom); addr0 = 3'($urandom); wdata0 = 8'($urandom); end
                    else gap[0]--;
                end
                if (!req1) begin
                    if (gap[1] == 0) begin req1 = 1; we1 = 1'($urandom); addr1 = 3'($urandom); wdata1 = 8'($urandom); end
                    else gap[1]--;
                end
            end
            if (busy && t == m_ack) begin
                busy = 0;
                if (m_port) req1 = 0; else req0 = 0;
                gap[m_port] = $urandom_range(0, 3);
                n_done[m_port]++;
            end
            if (!busy && t >= free_at && (req0 || req1)) begin
                m_port  = (req0 && req1) ? !m_last : req1;
                m_last  = m_port;
                m_we    = m_port ? we1 : we0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                m_strobe = t + 2;
                m_ack    = m_we ? t + 3 : t + 3 + RDW;
                free_at  = m_ack + 1;
                busy     = 1;
            end
            rdata = 8'($urandom);
            rd_hist[t] = rdata;
            step(1);
        end
        n_tests++; if (busy || n_done[0] == 0 || n_done[1] == 0) begin n_fail++; $display("FAIL rnd_progress got=busy%0d done%0d/%0d exp=idle with both ports served", busy, n_done[0], n_done[1]); end
    endtask

    initial begin
        #1;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_back_to_back();
        test_reset_mid();
        do_reset();
        test_rd_wait1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=no finish exp=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_reg_arbiter.md
# uart_reg_arbiter

- Shares the single UART register port between two requesters, for example an RX poller and a TX/config writer:
  - UART port signals: i_tx_en/waddr/wdata for writes; i_rx_en/raddr/rdata for reads.
- Each requester presents a register read or write and receives a one-cycle ack, plus read data for reads.
- The block arbitrates round-robin and runs the fixed strobe-and-wait sequence the UART register file requires.
- It sits between the UART core and the UART2AXIS / AXIS2UART style bridges, so bridges never drive the UART bus directly.

## Interface
Parameters:
- RD_WAIT, default 4: full cycles between the i_rx_en strobe cycle and the rdata sample edge. Legal range 1..15.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- reqN (N=0,1), in, 1: transaction request. Held high, with fields stable, until ackN.
- weN, in, 1: 1 = write, 0 = read.
- addrN, in, 3: UART register address.
- wdataN, in, 8: write data.
- ackN, out, 1: one-cycle completion pulse.
- rdataN, out, 8: read result. Updated only on read completion, otherwise held.
- i_tx_en, out, 1: UART write strobe.
- waddr, out, 3: UART write address.
- wdata, out, 8: UART write data.
- i_rx_en, out, 1: UART read strobe.
- raddr, out, 3: UART read address.
- rdata, in, 8: UART read data.

## Operation
- All outputs are registered. Reset value of every output is 0, and the round-robin pointer is reset so that port 0 wins the first tie.
- FSM states: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE:
  - If any reqN is high, grant one, latch we/addr/wdata of the granted port, and go to SETUP.
  - On a write, drive waddr/wdata; on a read, drive raddr. Registers for the unused direction keep their old values.
- SETUP: assert i_tx_en (write) or i_rx_en (read); go to STROBE.
- STROBE:
  - Deassert the strobe.
  - Write: go to DONE.
  - Read: load cnt = RD_WAIT-1 and go to WAIT.
- WAIT:
  - Decrement cnt.
  - When cnt==0: capture rdata into rdataN of the granted port, go to DONE.
- DONE:
  - ackN of the granted port is high during this state only.
  - Next state is IDLE.
  - req is not sampled in DONE, so a still-high req cannot be reissued.
- Arbitration:
  - Only one req high: that port is granted.
  - Both high in IDLE: grant the port that was not granted last.
  - The pointer updates on every grant.
- Non-granted requests wait. There is no preemption: a granted transaction always completes, unless reset intervenes.
- Exactly one of i_tx_en / i_rx_en is high at any time, or neither.

## Timing
- Cycle 0 is the IDLE cycle in which req is seen high.
- Cycle 1: address/data valid on the UART bus.
- Cycle 2: strobe high, for exactly one cycle.
- Write: ack high in cycle 3. The next grant is possible in cycle 4.
- Read:
  - WAIT occupies cycles 3..2+RD_WAIT.
  - rdata is sampled at the end of cycle 2+RD_WAIT.
  - ack and the new rdataN are visible in cycle 3+RD_WAIT (cycle 7 at default).
- Minimum spacing between strobes is 4 cycles (writes) or 4+RD_WAIT cycles (reads).
- Reset mid-transaction: the next edge forces IDLE, strobes and all outputs go to 0, and no ack is issued for the aborted transaction.
- A requester dropping req mid-transaction is illegal; the transaction still completes and acks.

## Structure
- Shared package uart_regs_pkg:
  - Register addresses: RBR_THR=0, LCR=3, LSR=5.
  - LSR bit masks: DR=8'h01, TEMT=8'h40.
  - State enum.
- Counter width is $clog2(16).
- Sub-module rr_arb2: two-request round-robin picker.
  - Inputs: req[1:0], last.
  - Output: grant index.
  - Combinational; the pointer register stays in the parent.

## Test plan
- Port0 write addr=3, data=8'h03 -> waddr=3 and wdata=03 in cycle 1, i_tx_en high in cycle 2 only, ack0 in cycle 3, i_rx_en never high.
- Port1 read addr=5 with rdata=8'h61 driven from cycle 3 on -> raddr=5 in cycle 1, i_rx_en in cycle 2, ack1 and rdata1=8'h61 in cycle 7, rdata0 unchanged.
- Both req high from reset -> port0 granted first, port1 granted in the cycle after ack0; repeated simultaneous requests alternate 0,1,0,1.
- Back-to-back port0 reads with req held continuously -> one strobe per transaction, no duplicate i_rx_en, strobe spacing = 8 cycles at RD_WAIT=4.
- rst asserted in WAIT of a read -> next cycle all outputs 0, no ack; the first post-reset request completes normally.
- RD_WAIT=1 -> read ack in cycle 4, rdata sampled at the end of cycle 3.
